st_buf: RTL and testbench

ST_BUF -- requirements
Module: st_buf

---
 rtl/st_buf_pkg.sv | 20 ++
 rtl/st_buf_align.sv | 36 +++
 rtl/st_buf.sv | 118 +++++++++++
 tb/tb_st_buf.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/st_buf_pkg.sv
// Shared load/store control encodings for the memory stage.
package st_buf_pkg;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_B    = 2'b01,
    ST_H    = 2'b10,
    ST_W    = 2'b11
  } st_ctr_e;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_B    = 3'b001,
    LD_H    = 3'b010,
    LD_W    = 3'b011,
    LD_BU   = 3'b101,
    LD_HU   = 3'b110
  } ld_ctr_e;

endpackage

// File: rtl/st_buf_align.sv
// Store lane alignment: byte enables, replicated write data and misalignment detect.
module st_align
  import st_buf_pkg::*;
(
  input  logic [1:0]  st_ctr_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  always_comb begin
    be_o       = 4'b0000;
    data_o     = 32'h0;
    misalign_o = 1'b0;
    unique case (st_ctr_e'(st_ctr_i))
      ST_B: begin
        be_o   = 4'b0001 << addr_i;
        data_o = {4{wdata_i[7:0]}};
      end
      ST_H: begin
        be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
        data_o     = {2{wdata_i[15:0]}};
        misalign_o = addr_i[0];
      end
      ST_W: begin
        be_o       = 4'b1111;
        data_o     = wdata_i;
        misalign_o = (addr_i != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/st_buf.sv
// Store buffer: circular FIFO of aligned word writes drained to data memory.
module st_buf
  import st_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [1:0]  ST_CTR,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        st_ready,
  output logic        st_misalign,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [29:0] ld_addr,
  output logic        ld_conflict
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic            misalign_q, misalign_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [29:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [3:0]      be_q   [DEPTH];

  logic [3:0]  al_be;
  logic [31:0] al_data;
  logic        al_misalign;
  logic        req_live, push, pop;

  st_align u_align (
    .st_ctr_i   (ST_CTR),
    .addr_i     (addr[1:0]),
    .wdata_i    (wdata),
    .be_o       (al_be),
    .data_o     (al_data),
    .misalign_o (al_misalign)
  );

  assign st_ready    = (count_q < Full);
  assign st_misalign = misalign_q;
  assign dm_req      = (count_q != '0);
  assign dm_addr     = {addr_q[head_q], 2'b00};
  assign dm_wdata    = data_q[head_q];
  assign dm_be       = be_q[head_q];

  assign req_live = st_valid & st_ready & (st_ctr_e'(ST_CTR) != ST_NONE);
  assign push     = req_live & ~al_misalign;
  assign pop      = dm_req & dm_ack;

  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    valid_d    = valid_q;
    misalign_d = req_live & al_misalign;
    if (pop) begin
      head_d          = head_q + PtrW'(1);
      valid_d[head_q] = 1'b0;
    end
    if (push) begin
      tail_d          = tail_q + PtrW'(1);
      valid_d[tail_q] = 1'b1;
    end
    // Push and pop together leave occupancy unchanged.
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == ld_addr)) begin
        ld_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      valid_q    <= '0;
      misalign_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      if (push) begin
        addr_q[tail_q] <= addr[31:2];
        data_q[tail_q] <= al_data;
        be_q[tail_q]   <= al_be;
      end
    end
  end

endmodule

// File: tb/tb_st_buf.sv
// Directed-vector bench for st_buf with DEPTH=2.
module tb_st_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [1:0]  ST_CTR;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        st_ready;
  logic        st_misalign;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [29:0] ld_addr;
  logic        ld_conflict;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  st_buf #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .ST_CTR      (ST_CTR),
    .addr        (addr),
    .wdata       (wdata),
    .st_ready    (st_ready),
    .st_misalign (st_misalign),
    .dm_req      (dm_req),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_be       (dm_be),
    .dm_ack      (dm_ack),
    .ld_addr     (ld_addr),
    .ld_conflict (ld_conflict)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ctr, input logic [31:0] a,
                       input logic [31:0] d);
    st_valid = v;
    ST_CTR   = ctr;
    addr     = a;
    wdata    = d;
  endtask

  initial begin
    rst = 1'b1;
    dm_ack = 1'b0;
    ld_addr = '0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    step();
    rst = 1'b0;
    check("rst_dm_req", dm_req, 0);
    check("rst_dm_addr", dm_addr, 0);
    check("rst_dm_wdata", dm_wdata, 0);
    check("rst_dm_be", dm_be, 0);
    check("rst_st_ready", st_ready, 1);
    check("rst_ld_conflict", ld_conflict, 0);
    check("rst_misalign", st_misalign, 0);

    // sb to lane 3 with ack already high
    dm_ack = 1'b1;
    drive(1'b1, 2'b01, 32'h103, 32'h0000_00A5);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("sb_req", dm_req, 1);
    check("sb_addr", dm_addr, 32'h100);
    check("sb_be", dm_be, 4'b1000);
    check("sb_wdata", dm_wdata, 32'hA5A5_A5A5);
    step();
    check("sb_popped", dm_req, 0);

    // sb byte-enable per lane; also exercises pointer wrap
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b01, 32'h20 + i, 32'h0000_005A);
      step();
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      check($sformatf("sb_lane%0d_be", i), dm_be, 32'(4'b0001 << i));
      check($sformatf("sb_lane%0d_data", i), dm_wdata, 32'h5A5A_5A5A);
      step();
    end

    // sh upper half, then misaligned sh
    dm_ack = 1'b0;
    drive(1'b1, 2'b10, 32'h202, 32'h0000_1234);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("sh_be", dm_be, 4'b1100);
    check("sh_wdata", dm_wdata, 32'h1234_1234);
    check("sh_addr", dm_addr, 32'h200);
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    check("sh_popped", dm_req, 0);
    drive(1'b1, 2'b10, 32'h201, 32'h0000_1234);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("sh_mis_pulse", st_misalign, 1);
    check("sh_mis_noreq", dm_req, 0);
    step();
    check("sh_mis_oneshot", st_misalign, 0);

    // misaligned sw, then ST_CTR=00 no-op
    drive(1'b1, 2'b11, 32'h42, 32'hDEAD_BEEF);
    step();
    drive(1'b1, 2'b00, 32'h40, 32'h0);
    check("sw_mis_pulse", st_misalign, 1);
    check("sw_mis_noreq", dm_req, 0);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("none_nomis", st_misalign, 0);
    check("none_noreq", dm_req, 0);

    // fill with ack low; third store held until space appears
    drive(1'b1, 2'b11, 32'h10, 32'h1111_1111);
    step();
    drive(1'b1, 2'b11, 32'h14, 32'h2222_2222);
    step();
    check("full_ready", st_ready, 0);
    check("full_head", dm_addr, 32'h10);
    drive(1'b1, 2'b11, 32'h18, 32'h3333_3333);
    step();
    check("held_ready", st_ready, 0);
    check("held_head", dm_wdata, 32'h1111_1111);
    // pop while full with st_valid high: no enqueue this cycle
    dm_ack = 1'b1;
    step();
    check("pop1_ready", st_ready, 1);
    check("pop1_head", dm_addr, 32'h14);
    check("pop1_data", dm_wdata, 32'h2222_2222);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("pop2_head", dm_addr, 32'h18);
    check("pop2_data", dm_wdata, 32'h3333_3333);
    check("pop2_be", dm_be, 4'b1111);
    check("pop2_req", dm_req, 1);
    step();
    check("drained", dm_req, 0);

    // load conflict: buffered compared, in-flight not
    dm_ack = 1'b0;
    drive(1'b1, 2'b11, 32'h40, 32'hCAFE_0000);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    ld_addr = 30'h10;
    #1;
    check("ldc_hit", ld_conflict, 1);
    ld_addr = 30'h11;
    #1;
    check("ldc_miss", ld_conflict, 0);
    drive(1'b1, 2'b11, 32'h44, 32'hCAFE_0001);
    #1;
    check("ldc_inflight", ld_conflict, 0);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("ldc_second", ld_conflict, 1);
    check("ldc_full", st_ready, 0);

    // reset mid-operation with ack and a store present
    rst = 1'b1;
    dm_ack = 1'b1;
    drive(1'b1, 2'b11, 32'h80, 32'h5555_5555);
    step();
    rst = 1'b0;
    dm_ack = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("mrst_req", dm_req, 0);
    check("mrst_ready", st_ready, 1);
    check("mrst_ldc", ld_conflict, 0);
    check("mrst_addr", dm_addr, 0);
    step();
    check("mrst_idle", dm_req, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
